// File: rtl/gray_decoder.sv
// Gray-to-binary decoder with sequence-lock tracking: decodes each accepted
// Gray sample and checks that successive decodes step by +1 (mod 2^W).
//
// state  | meaning
// S_IDLE | no reference sample yet since reset
// S_ACQ  | counting consecutive good steps towards lock
// S_LOCK | sequence tracked; a bad step raises err and drops back to S_ACQ
module gray_decoder #(
  parameter int W      = 4,
  parameter int LOCK_N = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         din_valid,
  input  logic [W-1:0] din,
  output logic [W-1:0] bin_out,
  output logic         bin_valid,
  output logic         locked,
  output logic         err,
  output logic [7:0]   err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACQ  = 2'b01,
    S_LOCK = 2'b10
  } state_t;

  localparam logic [3:0]   LOCK_TGT = 4'(LOCK_N);
  localparam logic [W-1:0] ONE_W    = W'(1);

  state_t       state, state_n;
  logic [3:0]   gcnt, gcnt_n, gcnt_inc;
  logic [W-1:0] prev, dec, prev_inc;
  logic         good;
  logic         err_n;
  logic [7:0]   err_cnt_n, err_cnt_sat;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < W; i++) begin
      dec[i] = ^(din >> i);
    end
  end

  assign prev_inc    = prev + ONE_W;
  assign good        = (dec == prev_inc);
  assign gcnt_inc    = gcnt + 4'd1;
  assign err_cnt_sat = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_comb begin
    state_n   = state;
    gcnt_n    = gcnt;
    err_n     = 1'b0;
    err_cnt_n = err_cnt;
    case (state)
      S_IDLE: begin
        if (din_valid) begin
          state_n = S_ACQ;
          gcnt_n  = 4'd0;
        end
      end
      S_ACQ: begin
        if (din_valid) begin
          if (good) begin
            if (gcnt_inc == LOCK_TGT) begin
              state_n = S_LOCK;
              gcnt_n  = 4'd0;
            end else begin
              gcnt_n = gcnt_inc;
            end
          end else begin
            gcnt_n = 4'd0;
          end
        end
      end
      S_LOCK: begin
        if (din_valid && !good) begin
          err_n     = 1'b1;
          err_cnt_n = err_cnt_sat;
          state_n   = S_ACQ;
          gcnt_n    = 4'd0;
        end
      end
      default: begin
        state_n = S_IDLE;
        gcnt_n  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= S_IDLE;
      gcnt      <= 4'd0;
      prev      <= '0;
      bin_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_n;
      gcnt      <= gcnt_n;
      bin_valid <= din_valid;
      locked    <= (state_n == S_LOCK);
      err       <= err_n;
      err_cnt   <= err_cnt_n;
      if (din_valid) begin
        prev <= dec;
      end
    end
  end

  // The last accepted decode is both the reference for step checks and the output.
  assign bin_out = prev;

endmodule

// File: tb/tb_gray_decoder.sv
// Randomised scoreboard bench for gray_decoder: expectations come from an
// arithmetic model of the lock rules, checked by a free-running monitor.
module tb_gray_decoder;
  localparam int W      = 4;
  localparam int LOCK_N = 3;
  localparam int MODV   = 1 << W;

  logic         clk = 1'b0;
  logic         srst = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         locked;
  logic         err;
  logic [7:0]   err_cnt;

  gray_decoder #(.W(W), .LOCK_N(LOCK_N)) dut (
    .clk      (clk),
    .srst     (srst),
    .din_valid(din_valid),
    .din      (din),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int lk;
    int e;
    int ec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int  m_prev    = 0;
  bit  m_have    = 1'b0;
  int  m_run     = 0;
  bit  m_locked  = 1'b0;
  int  m_errs    = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_prev = 0; m_have = 1'b0; m_run = 0; m_locked = 1'b0; m_errs = 0;
  endtask

  task automatic model_accept(input int b);
    exp_t x;
    int   e;
    e = 0;
    if (!m_have) begin
      m_have = 1'b1;
      m_run  = 0;
    end else if (b == (m_prev + 1) % MODV) begin
      if (!m_locked) begin
        m_run++;
        if (m_run == LOCK_N) begin
          m_locked = 1'b1;
          m_run    = 0;
        end
      end
    end else begin
      if (m_locked) begin
        e        = 1;
        m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
        m_locked = 1'b0;
      end
      m_run = 0;
    end
    m_prev = b;
    x.bin = b; x.lk = int'(m_locked); x.e = e; x.ec = m_errs;
    q.push_back(x);
  endtask

  // one clock of stimulus; idle cycles also check that bin_out holds
  task automatic cyc(input bit v, input int b);
    srst      = 1'b0;
    din_valid = v;
    din       = v ? to_gray(b) : W'($urandom);
    if (v) model_accept(b % MODV);
    @(posedge clk); #2;
    if (!v) chk("hold_bin_out", int'(bin_out), m_prev);
  endtask

  task automatic do_reset(input bit v);
    srst      = 1'b1;
    din_valid = v;
    din       = W'($urandom);
    @(posedge clk); #2;
    srst      = 1'b0;
    din_valid = 1'b0;
    model_reset();
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_bin_valid", int'(bin_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
  endtask

  task automatic good_step();
    cyc(1'b1, (m_prev + 1) % MODV);
  endtask

  // monitor: every output expected exactly one cycle after issue
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (bin_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_bin_valid", 1, 0);
        end else begin
          x = q.pop_front();
          chk("bin_out", int'(bin_out), x.bin);
          chk("locked", int'(locked), x.lk);
          chk("err", int'(err), x.e);
          chk("err_cnt", int'(err_cnt), x.ec);
        end
      end else begin
        if (q.size() != 0) begin
          chk("missing_bin_valid", 0, 1);
          void'(q.pop_front());
        end
        if (err) chk("err_without_valid", int'(err), 0);
      end
    end
  end

  initial begin
    int r;
    @(posedge clk); #2;
    do_reset(1'b0);

    // Gray 0000,0001,0011,0010 -> 0,1,2,3, locks on the third good step
    cyc(1'b1, 0); cyc(1'b1, 1); cyc(1'b1, 2); cyc(1'b1, 3);
    chk("locked_at_3", int'(locked), 1);

    // run up through 15 and wrap to 0 while locked
    for (int b = 4; b <= 16; b++) cyc(1'b1, b % MODV);
    chk("wrap_locked", int'(locked), 1);
    chk("wrap_err_cnt", int'(err_cnt), 0);

    // locked at 5, jump to 8, then relock on 9,10,11
    for (int b = 1; b <= 5; b++) cyc(1'b1, b);
    cyc(1'b1, 8);
    chk("break_locked", int'(locked), 0);
    cyc(1'b1, 9); cyc(1'b1, 10); cyc(1'b1, 11);
    chk("relock", int'(locked), 1);

    // locked at 5, three idle gaps, then 6
    for (int b = 12; b <= 21; b++) cyc(1'b1, b % MODV);
    repeat (3) cyc(1'b0, 0);
    cyc(1'b1, 6);
    chk("gap_locked", int'(locked), 1);

    // six more breaks -> err_cnt 7, relock, then reset with a valid sample
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, (m_prev + 2) % MODV);
      repeat (LOCK_N) good_step();
    end
    chk("pre_rst_err_cnt", int'(err_cnt), 7);
    do_reset(1'b1);
    cyc(1'b1, 9);
    cyc(1'b1, 3);
    chk("post_rst_err_cnt", int'(err_cnt), 0);

    // random mix of good steps, jumps, idles and resets
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       do_reset(1'($urandom));
      else if (r < 25) cyc(1'b0, 0);
      else if (r < 85) good_step();
      else             cyc(1'b1, $urandom_range(0, MODV - 1));
    end

    // saturation: 260 lock/break rounds
    do_reset(1'b0);
    cyc(1'b1, $urandom_range(0, MODV - 1));
    for (int k = 0; k < 260; k++) begin
      repeat (LOCK_N) good_step();
      cyc(1'b1, (m_prev + 2 + $urandom_range(0, MODV - 3)) % MODV);
    end
    chk("sat_err_cnt", int'(err_cnt), 255);

    repeat (3) cyc(1'b0, 0);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
